// File: rtl/sha3_hex_tx_if.sv
// rtl/sha3_hex_tx_if.sv - digest-word input and ASCII character output handshake bundle
interface sha3_hex_tx_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        digest_done;

    modport master (
        output in_data,
        output in_valid,
        output tx_ready,
        input  in_ready,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  digest_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  tx_ready,
        output in_ready,
        output tx_data,
        output tx_valid,
        output busy,
        output digest_done
    );
endinterface

// File: rtl/sha3_hex_tx.sv
// rtl/sha3_hex_tx.sv - SHA3 digest words to ASCII hex characters for a UART TX (optional CR/LF via SHA3_HEX_CRLF_EN)
module sha3_hex_tx #(
    parameter int NUM_WORDS = 8,
    parameter int UPPER     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    sha3_hex_tx_if.slave bus
);

    localparam int             WW            = $clog2(NUM_WORDS + 1);
    localparam logic [WW-1:0]  LP_LAST_WORD  = WW'(NUM_WORDS - 1);
    localparam logic [7:0]     LP_ALPHA_BASE = (UPPER != 0) ? 8'h41 : 8'h61;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [31:0]   r_shift;
    logic [2:0]    r_nib;
    logic [WW-1:0] r_word;
    logic          r_done;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_nib_hs;
    logic          w_last_word;
    logic          w_digest_end;
    logic [7:0]    w_tx_data;
    logic          w_tx_valid;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return LP_ALPHA_BASE + {4'h0, nib} - 8'd10;
    endfunction

    // in_ready is forced low while reset is held so nothing is taken during reset
    assign w_in_ready  = rst_n && (r_state == ST_IDLE);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_nib_hs    = (r_state == ST_EMIT) && bus.tx_ready;
    assign w_last_word = (r_word == LP_LAST_WORD);

    assign bus.in_ready    = w_in_ready;
    assign bus.tx_data     = w_tx_data;
    assign bus.tx_valid    = w_tx_valid;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.digest_done = r_done;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state, character output and end-of-digest detection
    always_comb begin
        w_next_state = r_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        w_digest_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_tx_valid = 1'b1;
                w_tx_data  = hex_ascii(r_shift[31:28]);
                if (bus.tx_ready && (r_nib == 3'd7)) begin
                    if (!w_last_word) begin
                        w_next_state = ST_IDLE;
                    end else begin
`ifdef SHA3_HEX_CRLF_EN
                        w_next_state = ST_CR;
`else
                        w_next_state = ST_IDLE;
                        w_digest_end = 1'b1;
`endif
                    end
                end
            end
            ST_CR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'h0D;
                if (bus.tx_ready) begin
                    w_next_state = ST_LF;
                end
            end
            ST_LF: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'h0A;
                if (bus.tx_ready) begin
                    w_next_state = ST_IDLE;
                    w_digest_end = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // word latch, nibble shifting, word counting and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 32'h0;
            r_nib   <= 3'd0;
            r_word  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_digest_end;
            if (w_accept) begin
                r_shift <= bus.in_data;
                r_nib   <= 3'd0;
            end else if (w_nib_hs) begin
                r_shift <= {r_shift[27:0], 4'h0};
                r_nib   <= r_nib + 3'd1;
                if (r_nib == 3'd7) begin
                    // counter clears as soon as the final word is out so it never wraps
                    r_word <= w_last_word ? '0 : (r_word + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sha3_hex_tx.sv
// tb/tb_sha3_hex_tx.sv - self-checking bench for sha3_hex_tx
module tb_sha3_hex_tx;

`ifdef SHA3_HEX_CRLF_EN
    localparam int TERM = 2;
`else
    localparam int TERM = 0;
`endif
    localparam int DIG_CHARS = 64 + TERM;
    localparam int BOUND     = 20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha3_hex_tx_if bus1();
    sha3_hex_tx_if bus2();

    sha3_hex_tx #(.NUM_WORDS(8), .UPPER(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    sha3_hex_tx #(.NUM_WORDS(1), .UPPER(1)) u_dut_up (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic [31:0] w;
        logic [63:0] s;
    } vec_t;

    int checks = 0;
    int fails  = 0;
    int ready_pct = 100;
    int exp_done1 = 0;

    logic [7:0] rx1_q[$];
    logic [7:0] rx2_q[$];
    logic [7:0] exp_q[$];
    int   done1 = 0;
    int   done2 = 0;
    int   acc1 = 0;
    int   done_bad1 = 0;
    logic prev_hs1 = 1'b0;

    // collect accepted characters, done pulses and word acceptances
    always @(negedge clk) begin
        if (bus1.tx_valid && bus1.tx_ready) rx1_q.push_back(bus1.tx_data);
        if (bus2.tx_valid && bus2.tx_ready) rx2_q.push_back(bus2.tx_data);
        prev_hs1 <= bus1.tx_valid && bus1.tx_ready;
        if (bus1.digest_done) begin
            done1 <= done1 + 1;
            if (!prev_hs1 || ((rx1_q.size() % DIG_CHARS) != 0)) done_bad1 <= done_bad1 + 1;
        end
        if (bus2.digest_done) done2 <= done2 + 1;
        if (bus1.in_valid && bus1.in_ready) acc1 <= acc1 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s act=timeout exp=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus1.tx_ready = (int'($urandom_range(99)) < ready_pct);
        if (!bus1.in_valid) bus1.in_data = $urandom;
        if (!bus2.in_valid) bus2.in_data = $urandom;
    endtask

    task automatic model_word(input logic [31:0] w);
        string s;
        s = $sformatf("%08h", w);
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    endtask

    task automatic model_term();
        if (TERM != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic send_word1(input logic [31:0] w, input bit chk_busy);
        int n;
        bus1.in_data  = w;
        bus1.in_valid = 1'b1;
        n = 0;
        while (!bus1.in_ready && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) timeout("in_ready_wait");
        if (chk_busy) check("busy_between", bus1.busy, 0);
        tick();
        bus1.in_valid = 1'b0;
        bus1.in_data  = $urandom;
        model_word(w);
    endtask

    task automatic compare_rx1(input string name);
        int bad;
        bad = -1;
        check({name, "_len"}, rx1_q.size(), exp_q.size());
        for (int i = 0; i < rx1_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && rx1_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_data idx=%0d act=%h exp=%h", name, bad, rx1_q[bad], exp_q[bad]);
        end
        rx1_q.delete();
        exp_q.delete();
    endtask

    task automatic drain1(input string name);
        int n;
        n = 0;
        while (rx1_q.size() < exp_q.size() && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) timeout({name, "_drain"});
        repeat (2) tick();
        check({name, "_done"}, done1, exp_done1);
        compare_rx1(name);
    endtask

    task automatic run_digest(input int gap_max, input bit chk_busy);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(gap_max)) tick();
            send_word1($urandom, chk_busy && (i == 0));
        end
        model_term();
        exp_done1++;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] sha[8];
        string       sha_s;
        logic [7:0]  hold_d;
        int          n;
        int          acc_before;
        int          bad;

        vecs[0] = '{32'h0123ABCD, "0123ABCD"};
        vecs[1] = '{32'hFFFFFFFF, "FFFFFFFF"};
        vecs[2] = '{32'h00000000, "00000000"};
        vecs[3] = '{32'h9A5F0E71, "9A5F0E71"};
        vecs[4] = '{32'h89ABCDEF, "89ABCDEF"};
        sha = '{32'hA7FFC6F8, 32'hBF1ED766, 32'h51C14756, 32'hA061D662,
                32'hF580FF4D, 32'hE43B49FA, 32'h82D80A4B, 32'h80F8434A};
        sha_s = "a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a";

        rst_n = 1'b0;
        bus1.in_data = 32'h0; bus1.in_valid = 1'b0; bus1.tx_ready = 1'b1;
        bus2.in_data = 32'h0; bus2.in_valid = 1'b0; bus2.tx_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus1.in_ready, 0);
        check("rst_tx_valid", bus1.tx_valid, 0);
        check("rst_tx_data", bus1.tx_data, 8'h00);
        check("rst_busy", bus1.busy, 0);
        check("rst_done", bus1.digest_done, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", bus1.in_ready, 1);

        // known SHA3-256("") digest, tx_ready held high
        ready_pct = 100;
        bus1.tx_ready = 1'b1;
        bus1.in_data  = sha[0];
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("latency_valid", bus1.tx_valid, 1);
        check("latency_first", bus1.tx_data, 8'h61);
        model_word(sha[0]);
        repeat (8) tick();
        check("rate_count", rx1_q.size(), 8);
        check("rate_ready", bus1.in_ready, 1);
        for (int i = 1; i < 8; i++) send_word1(sha[i], 1'b0);
        model_term();
        exp_done1++;
        n = 0;
        while (rx1_q.size() < DIG_CHARS && n < BOUND) begin tick(); n++; end
        repeat (2) tick();
        check("sha_len", rx1_q.size(), DIG_CHARS);
        bad = -1;
        for (int i = 0; i < 64 && i < rx1_q.size(); i++)
            if (bad < 0 && rx1_q[i] !== sha_s[i]) bad = i;
        check("sha_text_first_bad", bad, -1);
        if (TERM != 0 && rx1_q.size() == DIG_CHARS) begin
            check("sha_cr", rx1_q[64], 8'h0D);
            check("sha_lf", rx1_q[65], 8'h0A);
        end
        check("sha_done", done1, exp_done1);
        compare_rx1("sha_model");

        // stall mid-word, then in_valid held high during EMIT
        send_word1($urandom, 1'b0);
        repeat (3) tick();
        check("stall_pre", bus1.tx_data, exp_q[3]);
        ready_pct = 0;
        bus1.tx_ready = 1'b0;
        hold_d = bus1.tx_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {bus1.tx_valid, bus1.tx_data}, {1'b1, hold_d});
        end
        ready_pct = 100;
        bus1.tx_ready = 1'b1;
        acc_before = acc1;
        bus1.in_data = $urandom;
        bus1.in_valid = 1'b1;
        n = 0;
        while (!bus1.in_ready && n < 100) begin
            check("hold_busy", bus1.busy, 1);
            tick();
            n++;
        end
        check("hold_wait", n, 5);
        model_word(bus1.in_data);
        tick();
        bus1.in_valid = 1'b0;
        tick();
        check("hold_accepts", acc1 - acc_before, 1);
        ready_pct = 60;
        for (int i = 2; i < 8; i++) begin
            repeat ($urandom_range(2)) tick();
            send_word1($urandom, 1'b0);
        end
        model_term();
        exp_done1++;
        drain1("stall_digest");

        // reset after the 5th character of the 3rd word
        ready_pct = 70;
        for (int i = 0; i < 3; i++) send_word1($urandom, 1'b0);
        n = 0;
        while (rx1_q.size() < 21 && n < BOUND) begin tick(); n++; end
        if (n >= BOUND) timeout("reset_point");
        rst_n = 1'b0;
        #1;
        check("midrst_tx_valid", bus1.tx_valid, 0);
        check("midrst_tx_data", bus1.tx_data, 8'h00);
        check("midrst_busy", bus1.busy, 0);
        check("midrst_in_ready", bus1.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx1_q.delete();
        exp_q.delete();
        #1;
        check("postrst_in_ready", bus1.in_ready, 1);
        ready_pct = 100;
        run_digest(0, 1'b0);
        drain1("post_reset");

        // two digests back to back
        run_digest(0, 1'b0);
        run_digest(0, 1'b1);
        drain1("back2back");

        // random gaps and tx_ready patterns
        for (int d = 0; d < 4; d++) begin
            ready_pct = 20 + int'($urandom_range(80));
            run_digest(3, 1'b1);
            drain1("random");
        end
        check("done_timing_bad", done_bad1, 0);

        // uppercase single-word digests
        for (int v = 0; v < 5; v++) begin
            bus2.in_data  = vecs[v].w;
            bus2.in_valid = 1'b1;
            n = 0;
            while (!bus2.in_ready && n < 100) begin tick(); n++; end
            tick();
            bus2.in_valid = 1'b0;
            n = 0;
            while (rx2_q.size() < 8 + TERM && n < 100) begin tick(); n++; end
            repeat (2) tick();
            check("upper_len", rx2_q.size(), 8 + TERM);
            bad = -1;
            for (int k = 0; k < 8 && k < rx2_q.size(); k++)
                if (bad < 0 && rx2_q[k] !== vecs[v].s[63-8*k -: 8]) bad = k;
            check("upper_first_bad", bad, -1);
            check("upper_done", done2, v + 1);
            rx2_q.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/sha3_hex_tx.md
SHA3_HEX_TX -- requirements
Module: sha3_hex_tx

Interface
- REQ-001: Parameter NUM_WORDS, default 8: number of 32-bit digest words per digest (8 words = SHA3-256).
- REQ-002: Parameter UPPER, default 0: 0 emits lowercase hex 'a'-'f'; 1 emits uppercase 'A'-'F'.
- REQ-003: clk  input  1  single system clock; all state on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: in_data  input  32  digest word from SHA3 wrapper out_data.
- REQ-006: in_valid  input  1  in_data valid (wrapper out_valid).
- REQ-007: in_ready  output  1  block accepts in_data this cycle (to wrapper out_ready).
- REQ-008: tx_data  output  8  ASCII character to UART TX.
- REQ-009: tx_valid  output  1  tx_data valid.
- REQ-010: tx_ready  input  1  UART TX accepts tx_data this cycle.
- REQ-011: busy  output  1  high in any state other than IDLE.
- REQ-012: digest_done  output  1  one-cycle pulse after the last character of a digest is accepted.

Function
- REQ-013: States SHALL be IDLE, EMIT, CR, LF; IDLE is the reset state.
- REQ-014: in_ready SHALL be high only in IDLE; a word is accepted on in_valid && in_ready, latched into a 32-bit shift register, nibble counter cleared to 0, next state EMIT.
- REQ-015: EMIT SHALL drive tx_valid=1 and tx_data = ASCII hex of shift register bits [31:28] (0-9 -> 0x30-0x39, 10-15 -> 0x61-0x66, or 0x41-0x46 if UPPER=1).
- REQ-016: tx_data and tx_valid SHALL remain stable until tx_valid && tx_ready; on that handshake the register shifts left 4 and the nibble counter increments.
- REQ-017: After the 8th nibble handshake the word counter (width clog2(NUM_WORDS+1)) increments; if it is below NUM_WORDS, next state is IDLE; otherwise terminate the digest (REQ-024/025).
- REQ-018: Latency: first tx_valid SHALL assert the cycle after the accepting in_valid/in_ready edge; with tx_ready held high, one character per cycle.
- REQ-019: in_valid during EMIT/CR/LF SHALL be ignored (in_ready=0); wrapper holds data.
- REQ-020: tx_ready without tx_valid SHALL have no effect.
- REQ-021: Word counter SHALL clear to 0 when a digest terminates; no wrap beyond NUM_WORDS.
- REQ-022: digest_done SHALL pulse exactly once per digest, in the cycle after the final accepted character.
- REQ-023: Unlatched in_data bits SHALL never affect tx_data.

Reset
- REQ-026: On rst_n low, asynchronously: state IDLE, in_ready=0 while in reset, tx_valid=0, tx_data=0x00, busy=0, digest_done=0, shift register, nibble and word counters 0.
- REQ-027: Reset mid-digest SHALL discard partial output; after release in_ready=1 in IDLE and the next word is treated as word 0.

Configuration
- REQ-024: Macro SHA3_HEX_CRLF_EN defined: after the last nibble of word NUM_WORDS-1, states CR then LF emit 0x0D then 0x0A under the same handshake; digest_done follows LF acceptance; then IDLE.
- REQ-025: SHA3_HEX_CRLF_EN undefined: CR/LF states unreachable, no terminator bytes; digest_done follows the last hex character; then IDLE.

Verification
- REQ-028: NUM_WORDS=8, tx_ready=1, words 0xA7FFC6F8,0xBF1ED766,0x51C14756,0xA061D662,0xF580FF4D,0xE43B49FA,0x82D80A4B,0x80F8434A (SHA3-256 of "") -> 64 chars "a7ffc6f8...80f8434a", first byte 0x61, then 0x0D 0x0A with CRLF_EN, digest_done once.
- REQ-029: word 0x0123ABCD, UPPER=1 -> 0x30 0x31 0x32 0x33 0x41 0x42 0x43 0x44.
- REQ-030: tx_ready low 10 cycles mid-word -> tx_data/tx_valid unchanged throughout, no characters lost or duplicated.
- REQ-031: in_valid held high during EMIT -> in_ready=0, word accepted only on return to IDLE, exactly once.
- REQ-032: rst_n pulsed low after 3rd word's 5th character -> tx_valid=0 immediately; new 8-word digest afterwards emits complete 64 characters.
- REQ-033: two digests back-to-back -> 2 x (64 [+2]) characters, digest_done pulses twice, busy=0 between.
